// File: rtl/uart_rx_pkg.sv
// Shared types and timing helpers for the UART RX frame sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int BIT_CNT_W = 4;

  // First oversample edge at which the sampler's majority vote is stable.
  function automatic int chk_edge(input int prescale);
    return prescale / 2 + 2;
  endfunction

  function automatic int last_edge(input int prescale);
    return prescale - 1;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample-edge and bit-index counters; edge wraps LAST->0 and bumps the bit index.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8,
  parameter int EDGE_W   = $clog2(PRESCALE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  output logic [EDGE_W-1:0]    edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam logic [EDGE_W-1:0] LAST_E = EDGE_W'(last_edge(PRESCALE));

  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;

  // Next-count logic: clear on frame exit or while disabled, otherwise count with wrap.
  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr || !en) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_q == LAST_E) begin
      edge_d = '0;
      bit_d  = bit_q + 4'd1;
    end else begin
      edge_d = edge_q + EDGE_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame-sequencing FSM: decodes checker strobes from state and counters.
// Optional saturating error-frame counter enabled by UART_RX_FRAME_ERR_CNT_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_in,
  input  logic                        par_en,
  input  logic                        strt_glitch,
  input  logic                        par_err,
  input  logic                        stp_err,
  output logic [$clog2(PRESCALE)-1:0] edge_cnt,
  output logic [3:0]                  bit_cnt,
  output logic                        dat_samp_en,
  output logic                        deser_en,
  output logic                        strt_chk_en,
  output logic                        par_chk_en,
  output logic                        stp_chk_en,
  output logic                        data_valid,
  output logic [7:0]                  frame_err_cnt
);

  localparam int EW = $clog2(PRESCALE);
  localparam logic [EW-1:0] CHK_E  = EW'(chk_edge(PRESCALE));
  localparam logic [EW-1:0] CHK1_E = EW'(chk_edge(PRESCALE) + 1);
  localparam logic [EW-1:0] LAST_E = EW'(last_edge(PRESCALE));
  localparam logic [3:0]    LAST_DATA_BIT = 4'(DATA_WIDTH);

  rx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      par_sticky_q, par_sticky_d;
  logic      stp_cap_q, stp_cap_d;
  logic      data_valid_q, data_valid_d;
  logic      cnt_clr, err_evt, at_chk, at_chk1, at_last, stp_bad;

  uart_rx_edge_bit_cnt #(
    .PRESCALE (PRESCALE),
    .EDGE_W   (EW)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != IDLE),
    .clr      (cnt_clr),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt)
  );

  assign at_chk  = (edge_cnt == CHK_E);
  assign at_chk1 = (edge_cnt == CHK1_E);
  assign at_last = (edge_cnt == LAST_E);
  // With small PRESCALE the stop result arrives on LAST itself, so use it live then.
  assign stp_bad = at_chk1 ? stp_err : stp_cap_q;

  // Next-state, flag capture and frame-accept decode.
  always_comb begin
    state_d      = state_q;
    par_en_d     = par_en_q;
    par_sticky_d = par_sticky_q;
    stp_cap_d    = stp_cap_q;
    data_valid_d = 1'b0;
    cnt_clr      = 1'b0;
    err_evt      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d  = START;
          par_en_d = par_en;
        end else begin
          state_d  = IDLE;
        end
      end
      START: begin
        if (at_last) begin
          state_d = strt_glitch ? IDLE : DATA;
          cnt_clr = strt_glitch;
          err_evt = strt_glitch;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (at_last && (bit_cnt == LAST_DATA_BIT)) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        par_sticky_d = at_chk1 ? (par_sticky_q | par_err) : par_sticky_q;
        state_d      = at_last ? STOP : PARITY;
      end
      STOP: begin
        stp_cap_d = at_chk1 ? stp_err : stp_cap_q;
        if (at_last) begin
          data_valid_d = !stp_bad && !par_sticky_q;
          err_evt      = stp_bad || par_sticky_q;
          state_d      = IDLE;
          cnt_clr      = 1'b1;
          par_sticky_d = 1'b0;
          stp_cap_d    = 1'b0;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // FSM state and captured frame flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      par_en_q     <= 1'b0;
      par_sticky_q <= 1'b0;
      stp_cap_q    <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      par_sticky_q <= par_sticky_d;
      stp_cap_q    <= stp_cap_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign dat_samp_en = (state_q != IDLE);
  assign strt_chk_en = (state_q == START)  && at_chk;
  assign deser_en    = (state_q == DATA)   && at_chk;
  assign par_chk_en  = (state_q == PARITY) && at_chk;
  assign stp_chk_en  = (state_q == STOP)   && at_chk;
  assign data_valid  = data_valid_q;

`ifdef UART_RX_FRAME_ERR_CNT_EN
  logic [7:0] ferr_q, ferr_d;

  // Saturating error-frame count.
  always_comb begin
    if (err_evt && (ferr_q != 8'hFF)) begin
      ferr_d = ferr_q + 8'd1;
    end else begin
      ferr_d = ferr_q;
    end
  end

  // Error-frame counter register; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_q <= 8'd0;
    end else begin
      ferr_q <= ferr_d;
    end
  end

  assign frame_err_cnt = ferr_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
  assign frame_err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (PRESCALE=8 and PRESCALE=16 instances).
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef UART_RX_FRAME_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       rx_in, par_en, strt_glitch, par_err, stp_err;
  logic [2:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
  logic [7:0] frame_err_cnt;

  logic       rx16, pe16, gl16, perr16, serr16;
  logic [3:0] edge16, bit16;
  logic       samp16, deser16, strt16, par16, stp16, dv16;
  logic [7:0] ferr16;

  uart_rx_ctrl #(.PRESCALE(8), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
    .frame_err_cnt(frame_err_cnt)
  );

  uart_rx_ctrl #(.PRESCALE(16), .DATA_WIDTH(8)) u_dut16 (
    .clk(clk), .rst(rst), .rx_in(rx16), .par_en(pe16), .strt_glitch(gl16),
    .par_err(perr16), .stp_err(serr16), .edge_cnt(edge16), .bit_cnt(bit16),
    .dat_samp_en(samp16), .deser_en(deser16), .strt_chk_en(strt16),
    .par_chk_en(par16), .stp_chk_en(stp16), .data_valid(dv16),
    .frame_err_cnt(ferr16)
  );

  int n_vec = 0;
  int n_err = 0;
  int f_cyc, n_deser, deser_off, n_strt, n_par, n_stp, n_dv_in, dv_end, lb, le;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one frame on the PRESCALE=8 instance, emulating the registered checkers.
  task automatic run8(input logic [7:0] data, input logic pe, input logic gl,
                      input logic perr, input logic serr, input logic low_end);
    logic ps, pp, pt;
    int   b, flen;
    flen = pe ? 88 : 80;
    f_cyc = 0; n_deser = 0; deser_off = 0; n_strt = 0; n_par = 0; n_stp = 0;
    n_dv_in = 0; lb = -1; le = -1;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    ps = 1'b0; pp = 1'b0; pt = 1'b0;
    par_en = pe;
    rx_in  = 1'b0;
    @(posedge clk); #1;
    while (dat_samp_en && f_cyc < 400) begin
      b = f_cyc / 8;
      par_en = ~pe;
      if (gl)                     rx_in = (f_cyc >= 1);
      else if (b == 0)            rx_in = 1'b0;
      else if (b <= 8)            rx_in = data[b-1];
      else if (pe && b == 9)      rx_in = ^data;
      else                        rx_in = 1'b1;
      if (low_end && f_cyc == flen - 1) rx_in = 1'b0;
      if (deser_en) begin
        n_deser++;
        if (edge_cnt != 3'd6) deser_off++;
      end
      n_strt  += int'(strt_chk_en);
      n_par   += int'(par_chk_en);
      n_stp   += int'(stp_chk_en);
      n_dv_in += int'(data_valid);
      lb = int'(bit_cnt);
      le = int'(edge_cnt);
      ps = strt_chk_en; pp = par_chk_en; pt = stp_chk_en;
      @(posedge clk); #1;
      f_cyc++;
      if (ps) strt_glitch = gl;
      if (pp) par_err     = perr;
      if (pt) stp_err     = serr;
    end
    dv_end = int'(data_valid);
    rx_in  = low_end ? 1'b0 : 1'b1;
  endtask

  initial begin
    int c, act, nd16, off16;
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    rx16 = 1'b1; pe16 = 1'b0; gl16 = 1'b0; perr16 = 1'b0; serr16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state with idle line.
    chk("rst_edge", int'(edge_cnt), 0);
    chk("rst_bit", int'(bit_cnt), 0);
    chk("rst_outs", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    chk("rst_ferr", int'(frame_err_cnt), 0);

    // Clean 0xA5, no parity.
    run8(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_cycles", f_cyc, 80);
    chk("a5_deser_n", n_deser, 8);
    chk("a5_deser_edge", deser_off, 0);
    chk("a5_strt_n", n_strt, 1);
    chk("a5_par_n", n_par, 0);
    chk("a5_stp_n", n_stp, 1);
    chk("a5_dv_early", n_dv_in, 0);
    chk("a5_last_bit", lb, 9);
    chk("a5_last_edge", le, 7);
    chk("a5_dv", dv_end, 1);
    chk("a5_idle_bit", int'(bit_cnt), 0);
    @(posedge clk); #1;
    chk("a5_dv_1cyc", int'(data_valid), 0);
    chk("a5_idle", int'(dat_samp_en), 0);

    // Parity frame with parity error.
    run8(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("perr_cycles", f_cyc, 88);
    chk("perr_par_n", n_par, 1);
    chk("perr_last_bit", lb, 10);
    chk("perr_dv", dv_end, 0);
    chk("perr_ferr", int'(frame_err_cnt), CNT_ON ? 1 : 0);

    // Parity frame, clean: sticky flag must have been cleared.
    run8(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pok_cycles", f_cyc, 88);
    chk("pok_dv", dv_end, 1);

    // Two-clock start glitch.
    run8(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("gl_cycles", f_cyc, 8);
    chk("gl_deser_n", n_deser, 0);
    chk("gl_last_bit", lb, 0);
    chk("gl_last_edge", le, 7);
    chk("gl_dv", dv_end, 0);
    chk("gl_ferr", int'(frame_err_cnt), CNT_ON ? 2 : 0);

    // Stop error with line low at STOP LAST, then back-to-back 0x3C.
    run8(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("serr_cycles", f_cyc, 80);
    chk("serr_dv", dv_end, 0);
    chk("serr_ferr", int'(frame_err_cnt), CNT_ON ? 3 : 0);
    run8(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_cycles", f_cyc, 80);
    chk("b2b_deser_n", n_deser, 8);
    chk("b2b_dv", dv_end, 1);
    chk("b2b_ferr", int'(frame_err_cnt), CNT_ON ? 3 : 0);

    // Reset in the middle of data bit 4.
    rx_in = 1'b0; par_en = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    c = 0;
    while (!(bit_cnt == 4'd4 && edge_cnt == 3'd3) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("mid_reach", int'(c < 200), 1);
    rx_in = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_edge", int'(edge_cnt), 0);
    chk("mid_bit", int'(bit_cnt), 0);
    chk("mid_outs", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid}), 0);
    chk("mid_ferr", int'(frame_err_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    act = 0;
    repeat (40) begin
      @(posedge clk); #1;
      act += int'(dat_samp_en | deser_en | strt_chk_en | par_chk_en | stp_chk_en | data_valid);
    end
    chk("post_rst_quiet", act, 0);

    // PRESCALE=16 clean frame.
    rx16 = 1'b0;
    @(posedge clk); #1;
    rx16 = 1'b1;
    c = 0; nd16 = 0; off16 = 0;
    while (samp16 && c < 400) begin
      nd16 += int'(deser16);
      if ((deser16 || strt16 || stp16) && edge16 != 4'd10) off16++;
      @(posedge clk); #1;
      c++;
    end
    chk("p16_cycles", c, 160);
    chk("p16_deser_n", nd16, 8);
    chk("p16_strobe_edge", off16, 0);
    chk("p16_dv", int'(dv16), 1);

    // PRESCALE=16 repeated false starts drive the counter into saturation.
    gl16 = 1'b1;
    rx16 = 1'b0;
    repeat (300 * 17 + 10) @(posedge clk);
    #1;
    rx16 = 1'b1;
    gl16 = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("p16_ferr_sat", int'(ferr16), CNT_ON ? 255 : 0);
    chk("p16_idle", int'(samp16), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame-sequencing FSM for the UART receiver.
- Drives sampler, deserializer, start/parity/stop checker enables from internal edge/bit counters.
- Collects checker error flags and issues a one-cycle data_valid per clean frame.
- Sits between the rx_in pin path and the RX datapath checkers, in the UART RX clock domain.

Parameters:
- PRESCALE, 8, oversampling clocks per bit; legal values 8, 16, 32.
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.

Ports:
- clk  in  1  RX oversampling clock.
- rst  in  1  asynchronous reset, active-high.
- rx_in  in  1  serial line, idle high.
- par_en  in  1  parity bit present in frame; sampled in IDLE only.
- strt_glitch  in  1  registered start-checker result, valid 1 cycle after strt_chk_en.
- par_err  in  1  registered parity-checker result, valid 1 cycle after par_chk_en.
- stp_err  in  1  registered stop-checker result, valid 1 cycle after stp_chk_en.
- edge_cnt  out  $clog2(PRESCALE)  current oversample index.
- bit_cnt  out  4  current bit index in frame (start = 0).
- dat_samp_en  out  1  data sampler enable.
- deser_en  out  1  deserializer shift strobe.
- strt_chk_en  out  1  start-check strobe.
- par_chk_en  out  1  parity-check strobe.
- stp_chk_en  out  1  stop-check strobe.
- data_valid  out  1  frame accepted pulse.
- frame_err_cnt  out  8  error-frame counter (optional feature).

Behaviour:
- Reset: state IDLE; all counters 0; all outputs 0.
- Reset asserted mid-frame aborts immediately; no data_valid.
- Constant CHK = PRESCALE/2+2: first edge on which the sampler's majority output is stable. LAST = PRESCALE-1.
- edge_cnt increments every clk outside IDLE and wraps LAST->0. bit_cnt increments on that wrap.
- dat_samp_en = 1 in every state except IDLE.
- States and transitions:
  - IDLE: counters held 0. rx_in==0 -> START, and latch par_en.
  - START: strt_chk_en pulses at edge CHK. At edge LAST: strt_glitch==1 -> IDLE (false start), else -> DATA.
  - DATA: deser_en pulses at edge CHK for each of DATA_WIDTH bits. After the last data bit's edge LAST -> PARITY if latched par_en, else STOP.
  - PARITY: par_chk_en pulses at CHK. par_err captured into a sticky flag at edge CHK+1. -> STOP at LAST.
  - STOP: stp_chk_en pulses at CHK. stp_err read at CHK+1. At edge LAST: data_valid = !stp_err_cap & !par_err_sticky for exactly one cycle. -> IDLE. Sticky flags cleared.
- All enables and strobes are one clk wide and registered-free (decoded from state+counters). data_valid is registered.
- rx_in low during STOP edge LAST does not skip IDLE. The next start is detected one cycle later in IDLE.
- Changes of par_en mid-frame are ignored.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_CNT_EN.
- Defined: frame_err_cnt increments (saturating at 255) on each STOP-exit with parity or stop error, and on each false start. Cleared only by rst.
- Undefined: frame_err_cnt tied to 0; no counter flops.

Decomposition:
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), CHK/LAST localparam functions, counter width constant.
- Sub-module uart_rx_edge_bit_cnt: edge/bit counters with enable and wrap.

Test Plan:
- PRESCALE=8, par_en=0, frame 0xA5 with good stop -> deser_en pulses 8 times at edge 6; data_valid high 1 cycle at bit_cnt=9, edge 7; FSM in IDLE next cycle.
- par_en=1, par_err forced 1 after par_chk_en -> no data_valid; frame_err_cnt 0->1 with macro defined.
- rx_in glitch low for 2 clks, strt_glitch=1 -> return to IDLE at edge 7 of bit 0; no deser_en pulses.
- stp_err=1 -> data_valid stays 0; next back-to-back frame 0x3C accepted cleanly.
- rst asserted at DATA bit 4 -> all outputs 0 same cycle; after release, idle line gives no strobes.
- PRESCALE=16: strobes at edge 10; 300 error frames -> frame_err_cnt saturates at 255.
